// File: rtl/wb_mem_target.sv
// Wishbone classic-cycle RAM target with byte-lane writes and a fixed wait-state count.
// Define WB_MEM_TARGET_ERR_EN to answer out-of-range word indices with err instead of wrapping.
module wb_mem_target #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     adr,
  input  logic [DATA_WIDTH-1:0]     dat_w,
  output logic [DATA_WIDTH-1:0]     dat_r,
  input  logic                      stb,
  input  logic                      cyc,
  input  logic                      we,
  input  logic [DATA_WIDTH/8-1:0]   sel,
  output logic                      ack,
  output logic                      err
);

  localparam int unsigned LANES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(LANES);
  localparam int unsigned AW    = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state;
  logic [3:0]              cnt;
  logic [AW-1:0]           row_q;
  logic                    oob_q;
  logic                    oob_d;
  logic                    we_q;
  logic [LANES-1:0]        sel_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic                    wr_en;
  logic [DATA_WIDTH-1:0]   mem [DEPTH_WORDS];

  // Byte-offset bits and, without error checking, the upper index bits are ignored.
  logic unused_adr;
  assign unused_adr = ^adr;

`ifdef WB_MEM_TARGET_ERR_EN
  logic err_q;
  assign err   = err_q;
  assign oob_d = |(adr >> (LSB + AW));
`else
  assign err   = 1'b0;
  assign oob_d = 1'b0;
`endif

  // A reset on the response edge drops the write along with the transfer.
  assign wr_en = (state == RESP) && we_q && !oob_q && !reset;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < LANES; i++) begin
        if (sel_q[i]) mem[row_q][8*i +: 8] <= dat_q[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      dat_r <= '0;
`ifdef WB_MEM_TARGET_ERR_EN
      err_q <= 1'b0;
`endif
    end else begin
      ack   <= 1'b0;
      dat_r <= '0;
`ifdef WB_MEM_TARGET_ERR_EN
      err_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (cyc && stb) begin
            row_q <= adr[LSB +: AW];
            oob_q <= oob_d;
            we_q  <= we;
            sel_q <= sel;
            dat_q <= dat_w;
            cnt   <= 4'(WAIT_STATES);
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (!cyc) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
            if (cnt == 4'd1) state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          if (oob_q) begin
`ifdef WB_MEM_TARGET_ERR_EN
            err_q <= 1'b1;
`endif
          end else begin
            ack <= 1'b1;
            if (!we_q) dat_r <= mem[row_q];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_mem_target.sv
// Directed bench for wb_mem_target: three instances (0, 1 and 3 wait states) share the
// address/data bus and are selected by their own cyc/stb; responses are checked via a scoreboard.
module tb_wb_mem_target;

`ifdef WB_MEM_TARGET_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic        we;
  logic [3:0]  sel;
  logic        cyc   [3];
  logic        stb   [3];
  logic        ack   [3];
  logic        err   [3];
  logic [31:0] dat_r [3];

  int unsigned wsv [3] = '{0, 1, 3};

  always #5 clk = ~clk;

  wb_mem_target #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[0]), .stb(stb[0]),
    .cyc(cyc[0]), .we(we), .sel(sel), .ack(ack[0]), .err(err[0]));
  wb_mem_target #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[1]), .stb(stb[1]),
    .cyc(cyc[1]), .we(we), .sel(sel), .ack(ack[1]), .err(err[1]));
  wb_mem_target #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .reset(reset), .adr(adr), .dat_w(dat_w), .dat_r(dat_r[2]), .stb(stb[2]),
    .cyc(cyc[2]), .we(we), .sel(sel), .ack(ack[2]), .err(err[2]));

  typedef struct {
    logic        is_err;
    logic        is_read;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [3][256];
  int          total = 0;
  int          bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: compute the expected response and update the bench memory.
  task automatic predict(input int k, input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    exp_t        e;
    logic [31:0] cur;
    int          idx;
    logic        oob;
    idx = int'(a[9:2]);
    oob = (a[31:10] != 22'd0);
    cur = model[k][idx];
    e.is_err  = oob && ERR_EN;
    e.is_read = !wr && !e.is_err;
    e.data    = 32'd0;
    if (!e.is_err) begin
      if (wr) begin
        for (int i = 0; i < 4; i++) if (s[i]) cur[8*i +: 8] = d[8*i +: 8];
        model[k][idx] = cur;
      end else begin
        e.data = cur;
      end
    end
    sb.push_back(e);
  endtask

  task automatic xfer(input int k, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s, input string tag);
    exp_t e;
    bit   got;
    predict(k, wr, a, d, s);
    @(negedge clk);
    adr = a; dat_w = d; we = wr; sel = s; cyc[k] = 1'b1; stb[k] = 1'b1;
    @(posedge clk);
    got = 1'b0;
    for (int c = 1; c <= 20 && !got; c++) begin
      @(posedge clk); #1;
      check({tag, "_both"}, 32'(ack[k] & err[k]), 32'd0);
      if (ack[k] || err[k]) begin
        got = 1'b1;
        cyc[k] = 1'b0; stb[k] = 1'b0;
        e = sb.pop_front();
        check({tag, "_lat"}, c, wsv[k] + 1);
        check({tag, "_err"}, 32'(err[k]), 32'(e.is_err));
        check({tag, "_ack"}, 32'(ack[k]), 32'(!e.is_err));
        if (e.is_read || e.is_err) check({tag, "_data"}, dat_r[k], e.data);
      end else begin
        check({tag, "_dat_idle"}, dat_r[k], 32'd0);
      end
    end
    check({tag, "_timeout"}, 32'(got), 32'd1);
    if (!got) begin
      cyc[k] = 1'b0; stb[k] = 1'b0;
      void'(sb.pop_front());
    end
  endtask

  task automatic quiet(input int k, input int n, input string tag);
    for (int c = 0; c < n; c++) begin
      @(posedge clk); #1;
      check({tag, "_ack"}, 32'(ack[k]), 32'd0);
      check({tag, "_err"}, 32'(err[k]), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acks;
    reset = 1'b1; adr = '0; dat_w = '0; we = 1'b0; sel = '0;
    for (int k = 0; k < 3; k++) begin cyc[k] = 1'b0; stb[k] = 1'b0; end

    // Reset held 3 cycles, then idle.
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (c == 2) reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
        check("rst_ack", 32'(ack[k]), 32'd0);
        check("rst_err", 32'(err[k]), 32'd0);
        check("rst_dat", dat_r[k], 32'd0);
      end
    end

    // Write / read back with one wait state.
    xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "wr10");
    xfer(1, 1'b0, 32'h10, 32'h0,        4'hF, "rd10");

    // Byte lanes.
    xfer(1, 1'b1, 32'h20, 32'h11223344, 4'hF,    "bl_full");
    xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, "bl_part");
    xfer(1, 1'b0, 32'h20, 32'h0,        4'hF,    "bl_rd");

    // Abort with three wait states: cyc dropped one cycle after the request edge.
    xfer(2, 1'b1, 32'h30, 32'hA5A5A5A5, 4'hF, "ab_prior");
    @(negedge clk);
    adr = 32'h30; dat_w = 32'h55; we = 1'b1; sel = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    cyc[2] = 1'b0; stb[2] = 1'b0;
    quiet(2, 6, "ab_quiet");
    xfer(2, 1'b0, 32'h30, 32'h0, 4'hF, "ab_rd");

    // Out-of-range index 256 against a known word 0.
    xfer(1, 1'b1, 32'h0,   32'h12345678, 4'hF, "oob_w0");
    xfer(1, 1'b1, 32'h400, 32'hCAFE0001, 4'hF, "oob_wr");
    xfer(1, 1'b0, 32'h0,   32'h0,        4'hF, "oob_rd0");

    // Back-to-back writes with stb held and zero wait states.
    acks = 0;
    @(negedge clk);
    adr = 32'h80; dat_w = 32'hB0B00000; we = 1'b1; sel = 4'hF;
    predict(0, 1'b1, adr, dat_w, sel);
    cyc[0] = 1'b1; stb[0] = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      check("b2b_ack", 32'(ack[0]), 32'((c % 2 == 1) ? 1 : 0));
      if (ack[0]) begin
        acks++;
        void'(sb.pop_front());
        if (acks < 8) begin
          adr = 32'h80 + 32'(4 * acks); dat_w = 32'hB0B00000 | 32'(acks);
          predict(0, 1'b1, adr, dat_w, sel);
        end else begin
          cyc[0] = 1'b0; stb[0] = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(acks), 32'd8);
    cyc[0] = 1'b0; stb[0] = 1'b0;
    xfer(0, 1'b0, 32'h80, 32'h0, 4'hF, "b2b_rd0");
    xfer(0, 1'b0, 32'h9C, 32'h0, 4'hF, "b2b_rd7");

    // Reset asserted while the target is in WAIT.
    xfer(2, 1'b1, 32'h40, 32'h0BADF00D, 4'hF, "rw_prior");
    @(negedge clk);
    adr = 32'h40; dat_w = 32'hFFFFFFFF; we = 1'b1; sel = 4'hF; cyc[2] = 1'b1; stb[2] = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; cyc[2] = 1'b0; stb[2] = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rw_rst_ack", 32'(ack[2]), 32'd0);
    quiet(2, 6, "rw_quiet");
    xfer(2, 1'b0, 32'h40, 32'h0, 4'hF, "rw_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
